l3_req_arbiter: RTL and testbench

- Front-end request stage for the shared L3 cache array. Accepts word requests from NUM_CLIENTS L2-side clients over valid/ready and arbitrates round-robin, one grant per cycle.
- Decodes each address into a bank index and a 5-bit word address, and drives the RAM32 bank ports (CLK/A/D/WE/Q).
- Returns read data or a write acknowledge to the originating client after a fixed latency.

---
 rtl/l3_pkg.sv | 23 ++
 rtl/l3_req_arbiter_rr.sv | 33 +++
 rtl/l3_req_arbiter.sv | 119 +++++++++++
 tb/tb_l3_req_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/l3_pkg.sv
// l3_pkg: shared constants and pipeline types for the L3 request front end
package l3_pkg;
   localparam int L3_NUM_BANKS = 12;
   localparam int L3_WORD_AW   = 5;
   localparam int L3_DW        = 32;
   localparam int L3_BANK_IW   = 4;
   localparam int L3_CID_W     = 3;

   typedef struct packed {
      logic                  we;
      logic [L3_BANK_IW-1:0] bank_idx;
      logic [L3_WORD_AW-1:0] word_addr;
      logic [L3_DW-1:0]      wdata;
   } l3_req_t;

   typedef struct packed {
      logic                  valid;
      logic [L3_CID_W-1:0]   client_id;
      logic                  we;
      logic [L3_BANK_IW-1:0] bank_idx;
      logic                  err;
   } l3_stage_t;
endpackage

// File: rtl/l3_req_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant, search starts one past the last granted index
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_d, ptr_q;
   int            idx;

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      idx   = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (req[idx] && grant == '0) begin
            grant[idx] = 1'b1;
            if (advance) ptr_d = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= PW'(N - 1);
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/l3_req_arbiter.sv
// l3_req_arbiter: round-robin L3 request front end driving RAM32 banks, fixed 3-cycle response
module l3_req_arbiter
   import l3_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int NUM_BANKS   = L3_NUM_BANKS,
   parameter int BANK_IW     = L3_BANK_IW,
   parameter int DW          = L3_DW
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_CLIENTS-1:0]             req_valid,
   output logic [NUM_CLIENTS-1:0]             req_ready,
   input  logic [NUM_CLIENTS-1:0]             req_we,
   input  logic [NUM_CLIENTS*(BANK_IW+5)-1:0] req_addr,
   input  logic [NUM_CLIENTS*DW-1:0]          req_wdata,
   output logic [NUM_CLIENTS-1:0]             rsp_valid,
   output logic [DW-1:0]                      rsp_rdata,
   output logic                               rsp_err,
   output logic [4:0]                         bank_a,
   output logic [DW-1:0]                      bank_d,
   output logic [NUM_BANKS-1:0]               bank_we,
   input  logic [NUM_BANKS*DW-1:0]            bank_q
);
   localparam int AW = BANK_IW + L3_WORD_AW;

   logic [NUM_CLIENTS-1:0] req_v, grant;
   logic [L3_CID_W-1:0]    gnt_id;
   l3_req_t                req_sel;
   l3_stage_t              s1_d, s1_q, s2_q;
   logic [L3_WORD_AW-1:0]  bank_a_d, bank_a_q;
   logic [DW-1:0]          bank_d_d, bank_d_q, rsp_rdata_d, rsp_rdata_q;
   logic [NUM_BANKS-1:0]   bank_we_d, bank_we_q;
   logic [NUM_CLIENTS-1:0] rsp_valid_d, rsp_valid_q;
   logic                   rsp_err_d, rsp_err_q;
   logic [DW-1:0]          q_arr [2**BANK_IW];

   // Grants are suppressed while reset is held so req_ready reads zero
   assign req_v = req_valid & {NUM_CLIENTS{rst_n}};

   rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_v),
      .advance (|req_v),
      .grant   (grant)
   );

   // Unused bank-index codes read as zero so the S3 mux never indexes past the bank array
   for (genvar b = 0; b < 2**BANK_IW; b++) begin : g_q
      if (b < NUM_BANKS) begin : g_bank
         assign q_arr[b] = bank_q[b*DW +: DW];
      end else begin : g_pad
         assign q_arr[b] = '0;
      end
   end

   always_comb begin
      req_sel = '0;
      gnt_id  = '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
         if (grant[c]) begin
            gnt_id  = L3_CID_W'(c);
            req_sel = '{we:        req_we[c],
                        bank_idx:  req_addr[c*AW+L3_WORD_AW +: BANK_IW],
                        word_addr: req_addr[c*AW +: L3_WORD_AW],
                        wdata:     req_wdata[c*DW +: DW]};
         end
      end
      s1_d = '{valid:     |grant,
               client_id: gnt_id,
               we:        req_sel.we,
               bank_idx:  req_sel.bank_idx,
               err:       int'(req_sel.bank_idx) >= NUM_BANKS};
      bank_a_d  = |grant ? req_sel.word_addr : bank_a_q;
      bank_d_d  = |grant ? req_sel.wdata : bank_d_q;
      bank_we_d = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         bank_we_d[b] = s1_d.valid && req_sel.we && int'(req_sel.bank_idx) == b;
   end

   always_comb begin
      rsp_valid_d = '0;
      for (int c = 0; c < NUM_CLIENTS; c++)
         rsp_valid_d[c] = s2_q.valid && int'(s2_q.client_id) == c;
      rsp_err_d   = s2_q.valid && s2_q.err;
      rsp_rdata_d = (s2_q.valid && !s2_q.we && !s2_q.err) ? q_arr[s2_q.bank_idx] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         bank_a_q    <= '0;
         bank_d_q    <= '0;
         bank_we_q   <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s1_q;
         bank_a_q    <= bank_a_d;
         bank_d_q    <= bank_d_d;
         bank_we_q   <= bank_we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = grant;
   assign bank_a    = bank_a_q;
   assign bank_d    = bank_d_q;
   assign bank_we   = bank_we_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_l3_req_arbiter.sv
// tb_l3_req_arbiter: directed vectors with a response scoreboard and RAM32 bank models
module tb_l3_req_arbiter;
   localparam int NC = 4;
   localparam int NB = 12;
   localparam int IW = 4;
   localparam int DW = 32;
   localparam int AW = IW + 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NC-1:0]     req_valid = '0;
   logic [NC-1:0]     req_ready;
   logic [NC-1:0]     req_we = '0;
   logic [NC*AW-1:0]  req_addr = '0;
   logic [NC*DW-1:0]  req_wdata = '0;
   logic [NC-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic [4:0]        bank_a;
   logic [DW-1:0]     bank_d;
   logic [NB-1:0]     bank_we;
   logic [NB*DW-1:0]  bank_q;

   typedef struct {
      logic [NC-1:0] vmask;
      logic [DW-1:0] rdata;
      logic          err;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] exp_rd [NC];
   logic          exp_er [NC];
   logic [DW-1:0] mem [NB][32] = '{default: '0};
   logic [DW-1:0] q_r [NB] = '{default: '0};
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;

   l3_req_arbiter #(.NUM_CLIENTS(NC), .NUM_BANKS(NB), .BANK_IW(IW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bank_a    (bank_a),
      .bank_d    (bank_d),
      .bank_we   (bank_we),
      .bank_q    (bank_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM32 banks: synchronous write and synchronous read on the same edge
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (bank_we[b]) mem[b][bank_a] <= bank_d;
         q_r[b] <= mem[b][bank_a];
      end
   end

   always_comb begin
      bank_q = '0;
      for (int b = 0; b < NB; b++) bank_q[b*DW +: DW] = q_r[b];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e.vmask));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic set_req(input int c, input logic we, input logic [IW-1:0] bank, input logic [4:0] word,
                          input logic [DW-1:0] data, input logic [DW-1:0] rd, input logic er);
      req_we[c]            = we;
      req_addr[c*AW +: AW] = {bank, word};
      req_wdata[c*DW +: DW] = data;
      exp_rd[c]            = rd;
      exp_er[c]            = er;
   endtask

   task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] eg);
      req_valid = v;
      @(negedge clk);
      check("grant", 64'(req_ready), 64'(eg));
      for (int c = 0; c < NC; c++)
         if (eg[c]) sb.push_back('{vmask: eg, rdata: exp_rd[c], err: exp_er[c], due: cyc + 3});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 64'(req_ready), 64'(0));
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
      check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
      check({tag, "_bank_a"}, 64'(bank_a), 64'(0));
      check({tag, "_bank_d"}, 64'(bank_d), 64'(0));
      check({tag, "_bank_we"}, 64'(bank_we), 64'(0));
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         exp_rd[c] = '0;
         exp_er[c] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      set_req(1, 1'b1, 4'd3, 5'd7, 32'hCAFE_0001, 32'h0, 1'b0);
      step(4'b0010, 4'b0010);
      check("wr_bank_we", 64'(bank_we), 64'h008);
      check("wr_bank_a", 64'(bank_a), 64'd7);
      check("wr_bank_d", 64'(bank_d), 64'hCAFE_0001);
      set_req(1, 1'b0, 4'd3, 5'd7, 32'h0, 32'hCAFE_0001, 1'b0);
      step(4'b0010, 4'b0010);
      check("rd_bank_we", 64'(bank_we), 64'h000);
      set_req(1, 1'b1, 4'd5, 5'd31, 32'h1234_5678, 32'h0, 1'b0);
      step(4'b0010, 4'b0010);
      check("raw_bank_we", 64'(bank_we), 64'h020);
      set_req(1, 1'b0, 4'd5, 5'd31, 32'h0, 32'h1234_5678, 1'b0);
      step(4'b0010, 4'b0010);
      idle(4);

      set_req(3, 1'b0, 4'd12, 5'd0, 32'h0, 32'h0, 1'b1);
      step(4'b1000, 4'b1000);
      check("err12_bank_we", 64'(bank_we), 64'h000);
      set_req(3, 1'b0, 4'd15, 5'd3, 32'h0, 32'h0, 1'b1);
      step(4'b1000, 4'b1000);
      check("err15_bank_we", 64'(bank_we), 64'h000);
      set_req(3, 1'b1, 4'd12, 5'd2, 32'hDEAD_BEEF, 32'h0, 1'b1);
      step(4'b1000, 4'b1000);
      check("errwr_bank_we", 64'(bank_we), 64'h000);

      set_req(0, 1'b0, 4'd5, 5'd31, 32'h0, 32'h1234_5678, 1'b0);
      set_req(1, 1'b0, 4'd3, 5'd7, 32'h0, 32'hCAFE_0001, 1'b0);
      set_req(2, 1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      set_req(3, 1'b1, 4'd1, 5'd1, 32'hA5A5_0003, 32'h0, 1'b0);
      for (int k = 0; k < 8; k++) step(4'b1111, 4'(1 << (k % 4)));

      set_req(2, 1'b0, 4'd1, 5'd1, 32'h0, 32'hA5A5_0003, 1'b0);
      step(4'b0101, 4'b0001);
      step(4'b0101, 4'b0100);
      step(4'b0101, 4'b0001);
      step(4'b0101, 4'b0100);
      step(4'b0101, 4'b0001);
      step(4'b0001, 4'b0001);
      step(4'b0001, 4'b0001);
      idle(5);

      set_req(0, 1'b0, 4'd3, 5'd7, 32'h0, 32'hCAFE_0001, 1'b0);
      set_req(1, 1'b0, 4'd5, 5'd31, 32'h0, 32'h1234_5678, 1'b0);
      set_req(2, 1'b1, 4'd4, 5'd4, 32'hBEEF_0004, 32'h0, 1'b0);
      step(4'b0001, 4'b0001);
      step(4'b0010, 4'b0010);
      step(4'b0100, 4'b0100);
      req_valid = 4'b1111;
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_zero("midrst");
      @(negedge clk);
      req_valid = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(5);
      set_req(0, 1'b0, 4'd3, 5'd7, 32'h0, 32'hCAFE_0001, 1'b0);
      set_req(1, 1'b0, 4'd3, 5'd7, 32'h0, 32'hCAFE_0001, 1'b0);
      set_req(2, 1'b0, 4'd4, 5'd4, 32'h0, 32'h0, 1'b0);
      set_req(3, 1'b0, 4'd1, 5'd1, 32'h0, 32'hA5A5_0003, 1'b0);
      step(4'b1111, 4'b0001);
      step(4'b1111, 4'b0010);
      idle(6);
      check("drain", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
